// File: rtl/alu_seq_responder.sv
// alu_seq_responder: handshaked 8-bit ALU, single-cycle logic/add/sub/shift,
// 8-cycle shift-add multiply and restoring divide. Optional ALU_PERF_CNT_EN.
//   clk, rst_n         : clock, async active-low reset
//   req_valid/ready    : request handshake; req_a, req_b operands, req_sel opcode
//   rsp_valid/ready    : response handshake; rsp_result, rsp_carry, rsp_err
//   op_count           : (ALU_PERF_CNT_EN only) saturating handoff count
module alu_seq_responder #(
  parameter int DW   = 8,
  parameter int ITER = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [DW-1:0]   req_a,
  input  logic [DW-1:0]   req_b,
  input  logic [3:0]      req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_result,
  output logic            rsp_carry,
  output logic            rsp_err
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [15:0]     op_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            div_q;
  logic [2*DW-1:0] acc;
  logic [2:0]      cnt;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

  // single-cycle datapath, evaluated on the live request
  logic [DW:0]     sum9;
  logic [DW:0]     dif9;
  logic [2*DW-1:0] s_res;
  logic            s_cy;
  logic            s_err;
  logic            is_iter;

  assign sum9 = {1'b0, req_a} + {1'b0, req_b};
  assign dif9 = {1'b0, req_a} - {1'b0, req_b};
  assign is_iter = (req_sel == 4'b0010) || (req_sel == 4'b0011);

  always_comb begin
    s_res = '0;
    s_cy  = 1'b0;
    s_err = 1'b0;
    unique case (req_sel)
      4'b0000: begin
        s_res = {8'h00, sum9[DW-1:0]};
        s_cy  = sum9[DW];
      end
      4'b0001: begin
        s_res = {8'h00, dif9[DW-1:0]};
        s_cy  = dif9[DW];
      end
      4'b0100: s_res = {8'h00, req_a & req_b};
      4'b0101: s_res = {8'h00, req_a | req_b};
      4'b0110: s_res = {8'h00, req_a ^ req_b};
      4'b0111: s_res = {8'h00, ~req_a};
      4'b1000: begin
        s_res = {8'h00, req_a[DW-2:0], 1'b0};
        s_cy  = req_a[DW-1];
      end
      4'b1001: begin
        s_res = {8'h00, 1'b0, req_a[DW-1:1]};
        s_cy  = req_a[0];
      end
      4'b0010, 4'b0011: s_res = '0;
      default: s_err = 1'b1;
    endcase
  end

  // one iteration of multiply or divide
  logic [2*DW-1:0] mul_add;
  logic [2*DW-1:0] acc_mul;
  logic [DW:0]     rem_t;
  logic            ge;
  logic [DW-1:0]   rem_n;
  logic [2*DW-1:0] acc_div;
  logic [2*DW-1:0] acc_nx;

  assign mul_add = {8'h00, a_q} << cnt;
  assign acc_mul = b_q[cnt] ? acc + mul_add : acc;

  // acc = {remainder, dividend/quotient}; shift one dividend bit in
  assign rem_t   = {acc[2*DW-1:DW], acc[DW-1]};
  assign ge      = (rem_t >= {1'b0, b_q});
  assign rem_n   = ge ? DW'(rem_t - {1'b0, b_q})
                      : rem_t[DW-1:0];
  assign acc_div = {rem_n, acc[DW-2:0], ge};
  assign acc_nx  = div_q ? acc_div : acc_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      div_q      <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q <= req_a;
            b_q <= req_b;
            if (is_iter) begin
              state <= EXEC;
              cnt   <= '0;
              div_q <= req_sel[0];
              acc   <= req_sel[0] ? {8'h00, req_a} : '0;
            end else begin
              state      <= DONE;
              rsp_result <= s_res;
              rsp_carry  <= s_cy;
              rsp_err    <= s_err;
            end
          end
        end
        EXEC: begin
          acc <= acc_nx;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(ITER - 1)) begin
            state      <= DONE;
            rsp_result <= acc_nx;
            rsp_carry  <= 1'b0;
            rsp_err    <= div_q && (b_q == '0);
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready &&
                 op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: directed vectors with hand-computed results
// for alu_seq_responder, including backpressure and mid-op reset.
module tb_alu_seq_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
`ifdef ALU_PERF_CNT_EN
  logic [15:0] op_count;
`endif

  always #5 clk = ~clk;

  alu_seq_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err)
`ifdef ALU_PERF_CNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [3:0] sel);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("issue_ready", 32'(req_ready), 32'd1);
    req_a = a;
    req_b = b;
    req_sel = sel;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 8'($urandom);
    req_b = 8'($urandom);
    req_sel = 4'($urandom);
  endtask

  task automatic wait_rsp(output int lat, output logic busy);
    lat = 1;
    busy = 1'b0;
    while (!rsp_valid && lat < 30) begin
      busy |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("hs_valid", 32'(rsp_valid), 32'd0);
    chk("hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [3:0] sel,
                     input logic [15:0] e_res,
                     input logic e_cy,
                     input logic e_err,
                     input int e_lat);
    int lat;
    logic busy;
    issue(a, b, sel);
    wait_rsp(lat, busy);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_res"}, 32'(rsp_result), 32'(e_res));
    chk({tag, "_cy"}, 32'(rsp_carry), 32'(e_cy));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    handoff();
  endtask

  initial begin
    int lat;
    logic busy;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_res", 32'(rsp_result), 32'd0);
    chk("rst_cy", 32'(rsp_carry), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
`ifdef ALU_PERF_CNT_EN
    chk("rst_cnt", 32'(op_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("add", 8'd10, 8'd5, 4'b0000, 16'h000F, 1'b0, 1'b0, 1);
    run("addc", 8'hF0, 8'h20, 4'b0000, 16'h0010, 1'b1, 1'b0, 1);
    run("sub", 8'd5, 8'd10, 4'b0001, 16'h00FB, 1'b1, 1'b0, 1);
    run("shl", 8'h81, 8'h00, 4'b1000, 16'h0002, 1'b1, 1'b0, 1);
    run("shr", 8'h81, 8'h00, 4'b1001, 16'h0040, 1'b1, 1'b0, 1);
    run("and", 8'hCC, 8'hAA, 4'b0100, 16'h0088, 1'b0, 1'b0, 1);
    run("or",  8'hCC, 8'hAA, 4'b0101, 16'h00EE, 1'b0, 1'b0, 1);
    run("xor", 8'hCC, 8'hAA, 4'b0110, 16'h0066, 1'b0, 1'b0, 1);
    run("not", 8'hCC, 8'hAA, 4'b0111, 16'h0033, 1'b0, 1'b0, 1);
    run("mul", 8'd255, 8'd255, 4'b0010, 16'hFE01, 1'b0, 1'b0, 9);
    run("mul2", 8'd13, 8'd11, 4'b0010, 16'h008F, 1'b0, 1'b0, 9);
    run("div", 8'd10, 8'd3, 4'b0011, 16'h0103, 1'b0, 1'b0, 9);
    run("div0", 8'd10, 8'd0, 4'b0011, 16'h0AFF, 1'b0, 1'b1, 9);
    run("ill", 8'd10, 8'd3, 4'b1100, 16'h0000, 1'b0, 1'b1, 1);

    // backpressure with a competing request during DONE
    issue(8'd10, 8'd5, 4'b0000);
    wait_rsp(lat, busy);
    chk("bp_lat", 32'(lat), 32'd1);
    req_valid = 1'b1;
    req_a = 8'd1;
    req_b = 8'd1;
    req_sel = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_res", 32'(rsp_result), 32'h000F);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    handoff();
    @(posedge clk); #1;
    chk("bp_noacc", 32'(rsp_valid), 32'd0);

    // reset in the middle of a multiply
    issue(8'd255, 8'd255, 4'b0010);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_res", 32'(rsp_result), 32'd0);
    exp_cnt = 0;
`ifdef ALU_PERF_CNT_EN
    chk("mr_cnt", 32'(op_count), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      busy |= rsp_valid;
      @(posedge clk); #1;
    end
    chk("mr_novalid", 32'(busy), 32'd0);
    chk("mr_ready2", 32'(req_ready), 32'd1);
    run("add2", 8'd3, 8'd4, 4'b0000, 16'h0007, 1'b0, 1'b0, 1);
`ifdef ALU_PERF_CNT_EN
    chk("op_count", 32'(op_count), 32'(exp_cnt));
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
